// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode trap types: sequencer states, trap kinds and the
// interrupt cause codes used by the trap sequencer and its priority encoder.
package machine_mode_types_1_12_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_COMMIT,
        ST_REDIRECT
    } trap_state_e;

    typedef enum logic [1:0] {
        KIND_EXC,
        KIND_IRQ,
        KIND_MRET
    } trap_kind_e;

    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

endpackage

// File: rtl/priv_1_12_irq_prio.sv
// Machine interrupt priority encoder: picks MEI over MSI over MTI among
// interrupts that are both pending and enabled. Bit order is {e, t, s}.
module priv_1_12_irq_prio
    import machine_mode_types_1_12_pkg::*;
(
    input  logic [2:0] pend,
    input  logic [2:0] en,
    output logic       valid,
    output logic [3:0] code
);

    logic [2:0] act;

    always_comb begin
        act   = pend & en;
        valid = |act;
        code  = 4'd0;
        if (act[2]) begin
            code = IRQ_CODE_MEI;
        end else if (act[0]) begin
            code = IRQ_CODE_MSI;
        end else if (act[1]) begin
            code = IRQ_CODE_MTI;
        end
    end

endmodule

// File: rtl/priv_1_12_trap_seq.sv
// Machine-mode trap/MRET sequencer: IDLE -> FLUSH -> COMMIT -> REDIRECT.
// Define PRIV_VECTORED_IRQ_EN to honour vectored mtvec mode for interrupts.
module priv_1_12_trap_seq
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_req,
    input  logic [3:0]  ex_cause,
    input  logic [31:0] ex_epc,
    input  logic [31:0] ex_tval,
    input  logic        mret_req,
    input  logic [2:0]  irq_pend,
    input  logic [2:0]  irq_en,
    input  logic        mstatus_mie,
    input  logic        mstatus_mpie,
    input  logic        irq_ok,
    input  logic [31:0] irq_epc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        pipe_flush,
    output logic        busy,
    output logic        csr_trap_we,
    output logic        csr_mret_we,
    output logic [31:0] mepc_nxt,
    output logic [31:0] mcause_nxt,
    output logic [31:0] mtval_nxt,
    output logic        mie_nxt,
    output logic        mpie_nxt,
    output logic [31:0] new_pc,
    output logic        new_pc_valid,
    input  logic        pc_ack
);

    trap_state_e state_q, state_d;
    trap_kind_e  kind_q, kind_d;
    logic [3:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] tgt_q, tgt_d;
    logic        stat_q, stat_d;

    logic        irq_valid;
    logic [3:0]  irq_code;
    logic [31:0] tvec_base;
    logic [31:0] irq_tgt;
    logic        unused_low_bits;

    priv_1_12_irq_prio u_irq_prio (
        .pend  (irq_pend),
        .en    (irq_en),
        .valid (irq_valid),
        .code  (irq_code)
    );

    assign tvec_base       = {mtvec[31:2], 2'b00};
    assign unused_low_bits = ^{mepc[1:0], mtvec[1:0]};

`ifdef PRIV_VECTORED_IRQ_EN
    assign irq_tgt = (mtvec[1:0] == 2'b01)
                   ? tvec_base + (32'(VEC_STRIDE) * {28'd0, irq_code})
                   : tvec_base;
`else
    assign irq_tgt = tvec_base;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_EXC;
            code_q  <= 4'd0;
            epc_q   <= 32'd0;
            tval_q  <= 32'd0;
            tgt_q   <= 32'd0;
            stat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            tgt_q   <= tgt_d;
            stat_q  <= stat_d;
        end
    end

    // stat_q holds mstatus.MIE for traps and mstatus.MPIE for MRET, sampled at selection.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        code_d       = code_q;
        epc_d        = epc_q;
        tval_d       = tval_q;
        tgt_d        = tgt_q;
        stat_d       = stat_q;
        pipe_flush   = 1'b0;
        csr_trap_we  = 1'b0;
        csr_mret_we  = 1'b0;
        mepc_nxt     = 32'd0;
        mcause_nxt   = 32'd0;
        mtval_nxt    = 32'd0;
        mie_nxt      = 1'b0;
        mpie_nxt     = 1'b0;
        new_pc       = 32'd0;
        new_pc_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_req) begin
                    state_d = ST_FLUSH;
                    kind_d  = KIND_EXC;
                    code_d  = ex_cause;
                    epc_d   = ex_epc;
                    tval_d  = ex_tval;
                    tgt_d   = tvec_base;
                    stat_d  = mstatus_mie;
                end else if (mstatus_mie && irq_ok && irq_valid) begin
                    state_d = ST_FLUSH;
                    kind_d  = KIND_IRQ;
                    code_d  = irq_code;
                    epc_d   = irq_epc;
                    tval_d  = 32'd0;
                    tgt_d   = irq_tgt;
                    stat_d  = mstatus_mie;
                end else if (mret_req) begin
                    state_d = ST_FLUSH;
                    kind_d  = KIND_MRET;
                    code_d  = 4'd0;
                    epc_d   = 32'd0;
                    tval_d  = 32'd0;
                    tgt_d   = {mepc[31:2], 2'b00};
                    stat_d  = mstatus_mpie;
                end
            end
            ST_FLUSH: begin
                pipe_flush = 1'b1;
                state_d    = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_REDIRECT;
                if (kind_q == KIND_MRET) begin
                    csr_mret_we = 1'b1;
                    mie_nxt     = stat_q;
                    mpie_nxt    = 1'b1;
                end else begin
                    csr_trap_we = 1'b1;
                    mepc_nxt    = epc_q;
                    mcause_nxt  = {(kind_q == KIND_IRQ), 27'd0, code_q};
                    mtval_nxt   = tval_q;
                    mie_nxt     = 1'b0;
                    mpie_nxt    = stat_q;
                end
            end
            ST_REDIRECT: begin
                new_pc_valid = 1'b1;
                new_pc       = tgt_q;
                if (pc_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_priv_1_12_trap_seq.sv
// Directed self-checking bench for priv_1_12_trap_seq; expected redirect
// targets for interrupts follow PRIV_VECTORED_IRQ_EN.
module tb_priv_1_12_trap_seq;

   logic        CLK;
   logic        nRST;
   logic        ex_req;
   logic [3:0]  ex_cause;
   logic [31:0] ex_epc;
   logic [31:0] ex_tval;
   logic        mret_req;
   logic [2:0]  irq_pend;
   logic [2:0]  irq_en;
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic        irq_ok;
   logic [31:0] irq_epc;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        pipe_flush;
   logic        busy;
   logic        csr_trap_we;
   logic        csr_mret_we;
   logic [31:0] mepc_nxt;
   logic [31:0] mcause_nxt;
   logic [31:0] mtval_nxt;
   logic        mie_nxt;
   logic        mpie_nxt;
   logic [31:0] new_pc;
   logic        new_pc_valid;
   logic        pc_ack;

   int nChecks = 0;
   int nFails  = 0;

`ifdef PRIV_VECTORED_IRQ_EN
   localparam logic [31:0] EXP_PC_MEI = 32'h8000_002C;
   localparam logic [31:0] EXP_PC_MSI = 32'h8000_000C;
`else
   localparam logic [31:0] EXP_PC_MEI = 32'h8000_0000;
   localparam logic [31:0] EXP_PC_MSI = 32'h8000_0000;
`endif

   priv_1_12_trap_seq dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .ex_req       (ex_req),
      .ex_cause     (ex_cause),
      .ex_epc       (ex_epc),
      .ex_tval      (ex_tval),
      .mret_req     (mret_req),
      .irq_pend     (irq_pend),
      .irq_en       (irq_en),
      .mstatus_mie  (mstatus_mie),
      .mstatus_mpie (mstatus_mpie),
      .irq_ok       (irq_ok),
      .irq_epc      (irq_epc),
      .mtvec        (mtvec),
      .mepc         (mepc),
      .pipe_flush   (pipe_flush),
      .busy         (busy),
      .csr_trap_we  (csr_trap_we),
      .csr_mret_we  (csr_mret_we),
      .mepc_nxt     (mepc_nxt),
      .mcause_nxt   (mcause_nxt),
      .mtval_nxt    (mtval_nxt),
      .mie_nxt      (mie_nxt),
      .mpie_nxt     (mpie_nxt),
      .new_pc       (new_pc),
      .new_pc_valid (new_pc_valid),
      .pc_ack       (pc_ack)
   );

   // Free-running clock; rising edges at 5, 15, 25 ... so negedges fall mid-cycle.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Absolute time limit so a stuck run still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "[TB] timeout");
   end

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives the request inputs, then advances to the middle of the next cycle.
   task automatic applyStimulus(input logic ex, input logic mret, input logic [2:0] pend, input logic ack);
      ex_req   = ex;
      mret_req = mret;
      irq_pend = pend;
      pc_ack   = ack;
      @(negedge CLK);
   endtask

   // Directed sequence: each applyStimulus step lands mid-cycle in the next FSM state.
   initial begin
      nRST = 1'b0; ex_req = 1'b0; ex_cause = 4'd0; ex_epc = 32'd0; ex_tval = 32'd0;
      mret_req = 1'b0; irq_pend = 3'b000; irq_en = 3'b000; mstatus_mie = 1'b0;
      mstatus_mpie = 1'b0; irq_ok = 1'b0; irq_epc = 32'd0; mtvec = 32'd0; mepc = 32'd0;
      pc_ack = 1'b0;
      #2;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_flush", 32'(pipe_flush), 32'd0);
      checkOutput("rst_pcv", 32'(new_pc_valid), 32'd0);
      checkOutput("rst_trap_we", 32'(csr_trap_we), 32'd0);

      // Exception accepted on the very first edge after reset release.
      @(negedge CLK);
      nRST = 1'b1;
      ex_cause = 4'd2; ex_epc = 32'h100; ex_tval = 32'hDEAD; mtvec = 32'h8000_0000;
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
      checkOutput("exc_flush", 32'(pipe_flush), 32'd1);
      checkOutput("exc_busy_flush", 32'(busy), 32'd1);
      checkOutput("exc_no_we_in_flush", 32'(csr_trap_we), 32'd0);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("exc_trap_we", 32'(csr_trap_we), 32'd1);
      checkOutput("exc_mret_we", 32'(csr_mret_we), 32'd0);
      checkOutput("exc_mcause", mcause_nxt, 32'h2);
      checkOutput("exc_mepc", mepc_nxt, 32'h100);
      checkOutput("exc_mtval", mtval_nxt, 32'hDEAD);
      checkOutput("exc_mie", 32'(mie_nxt), 32'd0);
      checkOutput("exc_mpie", 32'(mpie_nxt), 32'd0);
      checkOutput("exc_flush_once", 32'(pipe_flush), 32'd0);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("exc_pcv", 32'(new_pc_valid), 32'd1);
      checkOutput("exc_new_pc", new_pc, 32'h8000_0000);
      checkOutput("exc_we_once", 32'(csr_trap_we), 32'd0);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
      checkOutput("exc_idle_busy", 32'(busy), 32'd0);
      checkOutput("exc_idle_pcv", 32'(new_pc_valid), 32'd0);

      // Interrupt gating: MIE off, then not interruptible, then nothing enabled.
      irq_en = 3'b100; mstatus_mie = 1'b0; irq_ok = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'b100, 1'b0);
      checkOutput("gate_mie_busy", 32'(busy), 32'd0);
      mstatus_mie = 1'b1; irq_ok = 1'b0;
      applyStimulus(1'b0, 1'b0, 3'b100, 1'b0);
      checkOutput("gate_ok_busy", 32'(busy), 32'd0);
      irq_ok = 1'b1; irq_en = 3'b011;
      applyStimulus(1'b0, 1'b0, 3'b100, 1'b0);
      checkOutput("gate_en_busy", 32'(busy), 32'd0);

      // All interrupts pending: MEI wins; pending drops after selection.
      irq_en = 3'b111; mtvec = 32'h8000_0001; irq_epc = 32'h444;
      applyStimulus(1'b0, 1'b0, 3'b111, 1'b0);
      checkOutput("mei_flush", 32'(pipe_flush), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("mei_trap_we", 32'(csr_trap_we), 32'd1);
      checkOutput("mei_mcause", mcause_nxt, 32'h8000_000B);
      checkOutput("mei_mepc", mepc_nxt, 32'h444);
      checkOutput("mei_mtval", mtval_nxt, 32'h0);
      checkOutput("mei_mpie", 32'(mpie_nxt), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      // Fetch stalls for five cycles; a new exception meanwhile must be ignored.
      ex_cause = 4'd9;
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_new_pc", new_pc, EXP_PC_MEI);
         checkOutput("stall_busy", 32'(busy), 32'd1);
         checkOutput("stall_pcv", 32'(new_pc_valid), 32'd1);
         applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
      end
      checkOutput("stall_new_pc_last", new_pc, EXP_PC_MEI);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
      checkOutput("stall_idle_busy", 32'(busy), 32'd0);

      // Exception, interrupt and MRET together: exception first, then MSI over MTI.
      ex_cause = 4'd5; ex_epc = 32'h300; ex_tval = 32'h11;
      applyStimulus(1'b1, 1'b1, 3'b011, 1'b0);
      checkOutput("pri_flush", 32'(pipe_flush), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b011, 1'b0);
      checkOutput("pri_trap_we", 32'(csr_trap_we), 32'd1);
      checkOutput("pri_mret_we", 32'(csr_mret_we), 32'd0);
      checkOutput("pri_mcause", mcause_nxt, 32'h5);
      checkOutput("pri_mepc", mepc_nxt, 32'h300);
      checkOutput("pri_mtval", mtval_nxt, 32'h11);
      applyStimulus(1'b0, 1'b0, 3'b011, 1'b0);
      checkOutput("pri_exc_base_pc", new_pc, 32'h8000_0000);
      applyStimulus(1'b0, 1'b0, 3'b011, 1'b1);
      checkOutput("pri_idle_busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 3'b011, 1'b0);
      checkOutput("msi_flush", 32'(pipe_flush), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("msi_mcause", mcause_nxt, 32'h8000_0003);
      checkOutput("msi_mepc", mepc_nxt, 32'h444);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("msi_new_pc", new_pc, EXP_PC_MSI);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
      checkOutput("msi_idle_busy", 32'(busy), 32'd0);

      // MRET restores MIE from MPIE and returns to word-aligned mepc.
      mepc = 32'h203; mstatus_mpie = 1'b1; mstatus_mie = 1'b0;
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
      checkOutput("mret_flush", 32'(pipe_flush), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("mret_we", 32'(csr_mret_we), 32'd1);
      checkOutput("mret_trap_we", 32'(csr_trap_we), 32'd0);
      checkOutput("mret_mie", 32'(mie_nxt), 32'd1);
      checkOutput("mret_mpie", 32'(mpie_nxt), 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput("mret_new_pc", new_pc, 32'h200);
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
      checkOutput("mret_idle_busy", 32'(busy), 32'd0);

      // Reset pulsed right as COMMIT begins: no CSR write afterwards.
      ex_cause = 4'd1;
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
      ex_req = 1'b0;
      @(posedge CLK);
      #1 nRST = 1'b0;
      #1;
      checkOutput("rstc_busy", 32'(busy), 32'd0);
      checkOutput("rstc_trap_we", 32'(csr_trap_we), 32'd0);
      checkOutput("rstc_mcause", mcause_nxt, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
         checkOutput("rstc_after_trap_we", 32'(csr_trap_we), 32'd0);
         checkOutput("rstc_after_busy", 32'(busy), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
